branch_unit: RTL and testbench

//   Program-counter and branch-resolution stage placed directly downstream of
//   the flags register. Consumes the registered flag_Z/flag_N and the decoded

---
 rtl/branch_unit_if.sv | 36 +++
 rtl/branch_unit.sv | 178 +++++++++++++++++
 tb/tb_branch_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_if.sv
// Interface between the decode/flags stages and the branch unit.
// The master drives the step request; the slave returns the PC and status.
interface branch_unit_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int STACK_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);

  // Step request
  logic                  pc_en;
  logic [3:0]            branch_op;
  logic [ADDR_WIDTH-1:0] target_addr;
  logic                  flag_Z;
  logic                  flag_N;

  // Program counter and status
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  branch_taken;
  logic [LEVEL_W-1:0]    stack_level;
  logic                  halted;
  logic                  fault;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output pc_en, branch_op, target_addr, flag_Z, flag_N,
    input  pc_out, branch_taken, stack_level, halted, fault,
           stack_overflow, stack_underflow
  );

  modport slave (
    input  pc_en, branch_op, target_addr, flag_Z, flag_N,
    output pc_out, branch_taken, stack_level, halted, fault,
           stack_overflow, stack_underflow
  );
endinterface

// File: rtl/branch_unit.sv
// Program counter and branch resolution with a return-address stack and
// a RUN/HALTED/FAULT state machine. One-cycle latency per enabled step.
module branch_unit #(
  parameter int ADDR_WIDTH   = 11,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic        clock,
  input  logic        pc_reset,
  branch_unit_if.slave bus
);

  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_JMP  = 4'd1,
    OP_BEQ  = 4'd2,
    OP_BNE  = 4'd3,
    OP_BGT  = 4'd4,
    OP_BGE  = 4'd5,
    OP_BLT  = 4'd6,
    OP_BLE  = 4'd7,
    OP_CALL = 4'd8,
    OP_RET  = 4'd9,
    OP_HALT = 4'd10
  } op_t;

  // Architectural state
  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
  logic [LEVEL_W-1:0]    level_q,  level_d;
  logic                  taken_q,  taken_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Step decode helpers
  logic                  step;
  logic                  push;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  cond_true;

  assign step        = bus.pc_en && (state_q == ST_RUN);
  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign push_idx    = IDX_W'(level_q);
  assign pop_idx     = IDX_W'(level_q - LEVEL_W'(1));
  assign stack_full  = (level_q == LEVEL_W'(STACK_DEPTH));
  assign stack_empty = (level_q == '0);

  // Conditional-branch predicate from the flags sampled at this edge
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.branch_op)
      OP_BEQ:  cond_true = bus.flag_Z;
      OP_BNE:  cond_true = !bus.flag_Z;
      OP_BGT:  cond_true = !bus.flag_Z && !bus.flag_N;
      OP_BGE:  cond_true = !bus.flag_N;
      OP_BLT:  cond_true = bus.flag_N;
      OP_BLE:  cond_true = bus.flag_N || bus.flag_Z;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state and next-PC logic
  // NOTE: every output of this block is defaulted first so no path through
  // the case statements leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    level_d = level_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;

    if (step) begin
      unique case (bus.branch_op)
        OP_JMP: begin
          pc_d    = bus.target_addr;
          taken_d = 1'b1;
        end

        OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
          if (cond_true) begin
            pc_d    = bus.target_addr;
            taken_d = 1'b1;
          end else begin
            pc_d    = pc_inc;
          end
        end

        OP_CALL: begin
          if (stack_full) begin
            ovf_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            push    = 1'b1;
            level_d = level_q + LEVEL_W'(1);
            pc_d    = bus.target_addr;
            taken_d = 1'b1;
          end
        end

        OP_RET: begin
          if (stack_empty) begin
            unf_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            level_d = level_q - LEVEL_W'(1);
            pc_d    = stack_mem[pop_idx];
            taken_d = 1'b1;
          end
        end

        OP_HALT: begin
          state_d = ST_HALTED;
        end

        // NOP and the unused opcodes 11-15 simply advance
        default: begin
          pc_d = pc_inc;
        end
      endcase
    end
  end

  // State register; reset overrides any step on the same edge
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (pc_reset) begin
      state_q <= ST_RUN;
      pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
      level_q <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      level_q <= level_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage
  // NOTE: the stack array is deliberately not reset; only level_q decides
  // which entries are meaningful, so the storage maps onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (push && !pc_reset) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.pc_out          = pc_q;
  assign bus.branch_taken    = taken_q;
  assign bus.stack_level     = level_q;
  assign bus.halted          = (state_q == ST_HALTED);
  assign bus.fault           = (state_q == ST_FAULT);
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: a behavioural model predicts each
// step, expectations are queued at drive time and compared after the edge.
module tb_branch_unit;

  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  localparam int NOP  = 0;
  localparam int JMP  = 1;
  localparam int BEQ  = 2;
  localparam int BNE  = 3;
  localparam int BGT  = 4;
  localparam int BGE  = 5;
  localparam int BLT  = 6;
  localparam int BLE  = 7;
  localparam int CALL = 8;
  localparam int RET  = 9;
  localparam int HALT = 10;

  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    int            level;
    logic          halted;
    logic          fault;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic clock = 1'b0;
  logic pc_reset;

  branch_unit_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) bus ();

  branch_unit #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(0)
  ) dut (
    .clock   (clock),
    .pc_reset(pc_reset),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference model
  logic [AW-1:0] m_pc;
  logic          m_taken;
  logic [AW-1:0] m_stack[$];
  int            m_state;   // 0 run, 1 halted, 2 fault
  logic          m_ovf;
  logic          m_unf;

  exp_t sb[$];

  function automatic logic cond(input int op, input logic z, input logic n);
    case (op)
      BEQ:     return z;
      BNE:     return !z;
      BGT:     return !z && !n;
      BGE:     return !n;
      BLT:     return n;
      BLE:     return n || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic rst, input logic en, input int op,
                       input logic [AW-1:0] tgt, input logic z, input logic n);
    if (rst) begin
      m_pc = '0; m_taken = 0; m_stack.delete(); m_state = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_taken = 0;
      if (en && m_state == 0) begin
        if (op == JMP) begin
          m_pc = tgt; m_taken = 1;
        end else if (op >= BEQ && op <= BLE) begin
          if (cond(op, z, n)) begin m_pc = tgt; m_taken = 1; end
          else m_pc = m_pc + 1'b1;
        end else if (op == CALL) begin
          if (m_stack.size() == DEPTH) begin m_ovf = 1; m_state = 2; end
          else begin m_stack.push_back(m_pc + 1'b1); m_pc = tgt; m_taken = 1; end
        end else if (op == RET) begin
          if (m_stack.size() == 0) begin m_unf = 1; m_state = 2; end
          else begin m_pc = m_stack.pop_back(); m_taken = 1; end
        end else if (op == HALT) begin
          m_state = 1;
        end else begin
          m_pc = m_pc + 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle, queue the prediction, compare after the edge
  task automatic step(input logic rst, input logic en, input int op,
                      input logic [AW-1:0] tgt, input logic z, input logic n);
    exp_t e;
    @(negedge clock);
    pc_reset        = rst;
    bus.pc_en       = en;
    bus.branch_op   = 4'(op);
    bus.target_addr = tgt;
    bus.flag_Z      = z;
    bus.flag_N      = n;
    model(rst, en, op, tgt, z, n);
    e.pc = m_pc; e.taken = m_taken; e.level = m_stack.size();
    e.halted = (m_state == 1); e.fault = (m_state == 2);
    e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc_out",          32'(bus.pc_out),          32'(e.pc));
      check("branch_taken",    32'(bus.branch_taken),    32'(e.taken));
      check("stack_level",     32'(bus.stack_level),     32'(e.level));
      check("halted",          32'(bus.halted),          32'(e.halted));
      check("fault",           32'(bus.fault),           32'(e.fault));
      check("stack_overflow",  32'(bus.stack_overflow),  32'(e.ovf));
      check("stack_underflow", 32'(bus.stack_underflow), 32'(e.unf));
    end
  endtask

  task automatic op1(input int op, input logic [AW-1:0] tgt);
    step(1'b0, 1'b1, op, tgt, 1'b0, 1'b0);
  endtask

  task automatic reset1();
    step(1'b1, 1'b0, NOP, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] frozen;
    pc_reset = 1'b1; bus.pc_en = 0; bus.branch_op = '0;
    bus.target_addr = '0; bus.flag_Z = 0; bus.flag_N = 0;

    // T1 reset and sequential fetch
    reset1();
    check("t1_reset_pc", 32'(bus.pc_out), 32'h0);
    for (int i = 0; i < 3; i++) op1(NOP, 11'h000);
    check("t1_pc3", 32'(bus.pc_out), 32'h3);

    // pc_en low holds PC and drops branch_taken
    op1(JMP, 11'h055);
    step(1'b0, 1'b0, JMP, 11'h123, 1'b0, 1'b0);
    check("idle_taken", 32'(bus.branch_taken), 32'h0);
    check("idle_pc",    32'(bus.pc_out),       32'h055);

    // T2 wrap and jump
    op1(JMP, 11'h7FF);
    op1(NOP, 11'h000);
    check("t2_wrap", 32'(bus.pc_out), 32'h000);
    op1(JMP, 11'h123);
    check("t2_jmp", 32'(bus.pc_out), 32'h123);

    // T3 conditional branches
    op1(JMP, 11'h03F);
    step(1'b0, 1'b1, BEQ, 11'h040, 1'b1, 1'b0);
    step(1'b0, 1'b1, BNE, 11'h080, 1'b1, 1'b0);
    check("t3_bne_nt", 32'(bus.pc_out), 32'h041);
    op1(JMP, 11'h0FF);
    step(1'b0, 1'b1, BLT, 11'h100, 1'b0, 1'b1);
    step(1'b0, 1'b1, BGE, 11'h200, 1'b0, 1'b1);
    check("t3_bge_nt", 32'(bus.pc_out), 32'h101);
    step(1'b0, 1'b1, BGT, 11'h300, 1'b0, 1'b0);
    check("t3_bgt", 32'(bus.pc_out), 32'h300);
    // Every cond op against every flag combination
    for (int op = BEQ; op <= BLE; op++)
      for (int f = 0; f < 4; f++)
        step(1'b0, 1'b1, op, 11'(12'h400 + op * 16 + f), f[0], f[1]);
    // Unused opcodes act as NOP
    for (int op = 11; op < 16; op++) op1(op, 11'h5AA);

    // T4 nested call/return
    op1(JMP, 11'h010);
    op1(CALL, 11'h050);
    op1(CALL, 11'h060);
    op1(RET, 11'h000);
    check("t4_ret1", 32'(bus.pc_out), 32'h051);
    op1(RET, 11'h000);
    check("t4_ret2", 32'(bus.pc_out), 32'h011);

    // T5 overflow, frozen fault, reset, underflow
    for (int i = 0; i < DEPTH; i++) op1(CALL, 11'(12'h100 * (i + 1)));
    frozen = bus.pc_out;
    op1(CALL, 11'h7AA);
    check("t5_ovf_pc", 32'(bus.pc_out), 32'(frozen));
    check("t5_ovf_fault", 32'(bus.fault), 32'h1);
    op1(RET, 11'h000);
    op1(JMP, 11'h222);
    reset1();
    op1(RET, 11'h000);
    check("t5_unf", 32'(bus.stack_underflow), 32'h1);
    op1(NOP, 11'h000);

    // T6 halt, frozen, reset together with an enabled jump
    reset1();
    op1(JMP, 11'h0C3);
    op1(HALT, 11'h000);
    for (int i = 0; i < 5; i++) op1(JMP, 11'h3AB);
    check("t6_frozen", 32'(bus.pc_out), 32'h0C3);
    step(1'b1, 1'b1, JMP, 11'h123, 1'b0, 1'b0);
    check("t6_rst_halted", 32'(bus.halted), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
